// File: rtl/mdclcg_pkg.sv
// Shared types and helpers for the MDCLCG datapath: shift-op encoding,
// default datapath width and a bit-reversal helper.
package mdclcg_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } shift_op_e;

  localparam int DEFAULT_WIDTH = 64;
  localparam int BITREV_MAX    = 256;

  // Reverses the low w bits of d into the low w bits of the result; callers
  // size-cast the return value down to their own width.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] d,
                                                   input int w);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX; i++) begin
      r[i] = d[BITREV_MAX-1-i];
    end
    return r >> (BITREV_MAX - w);
  endfunction

endpackage

// File: rtl/pipelined_shifter_level.sv
// One log-shifter mux level: optionally shifts left by AMT, filling the
// vacated low bits with either the fill bit or the wrapped-around high bits.
module shift_level #(
  parameter int WIDTH = 64,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             fill_i,
  input  logic             rot_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] data_o
);

  logic [AMT-1:0] low_bits;

  assign low_bits = rot_i ? data_i[WIDTH-1 -: AMT] : {AMT{fill_i}};
  assign data_o   = sel_i ? {data_i[WIDTH-AMT-1:0], low_bits} : data_i;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined variable shifter (SLL/SRL/SRA/ROL) built on a single left-shift
// core with a register every LVL_PER_REG levels and valid/ready back-pressure.
module pipelined_shifter
  import mdclcg_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SHW         = $clog2(WIDTH),
  parameter int LVL_PER_REG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int NSTG = (SHW + LVL_PER_REG - 1) / LVL_PER_REG;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             fill;
    shift_op_e        op;
    logic [SHW-1:0]   shift;
  } stage_t;

  stage_t           stage_in [NSTG];
  stage_t           stage_q  [NSTG];
  logic [NSTG-1:0]  valid_q;
  logic [NSTG:0]    load;
  logic [WIDTH-1:0] lvl_out  [SHW];

  shift_op_e        op_in;
  logic             rev_in;
  logic [WIDTH-1:0] data_pre;

  // Right shifts reuse the left-shift core by reversing the word on both ends.
  assign op_in    = shift_op_e'(in_op);
  assign rev_in   = (op_in == SRL) || (op_in == SRA);
  assign data_pre = rev_in ? WIDTH'(bitrev(BITREV_MAX'(in_data), WIDTH)) : in_data;

  assign load[NSTG] = out_ready;
  assign in_ready   = load[0];
  assign out_valid  = valid_q[NSTG-1];
  assign out_data   = stage_q[NSTG-1].data;

  genvar gi;
  genvar gk;

  generate
    for (gk = 0; gk < SHW; gk++) begin : g_lvl
      localparam int STG = gk / LVL_PER_REG;
      logic [WIDTH-1:0] lvl_in;

      if (gk % LVL_PER_REG == 0) begin : g_head
        assign lvl_in = stage_in[STG].data;
      end else begin : g_chain
        assign lvl_in = lvl_out[gk-1];
      end

      shift_level #(
        .WIDTH (WIDTH),
        .AMT   (1 << gk)
      ) u_level (
        .data_i (lvl_in),
        .fill_i (stage_in[STG].fill),
        .rot_i  (stage_in[STG].op == ROL),
        .sel_i  (stage_in[STG].shift[gk]),
        .data_o (lvl_out[gk])
      );
    end

    for (gi = 0; gi < NSTG; gi++) begin : g_stg
      localparam int LAST = (((gi + 1) * LVL_PER_REG < SHW) ? (gi + 1) * LVL_PER_REG : SHW) - 1;

      stage_t           stage_d;
      stage_t           stg_q;
      logic             valid_d;
      logic             vld_q;
      logic             up_valid;
      logic [WIDTH-1:0] res;

      if (gi == 0) begin : g_src_in
        assign up_valid    = in_valid;
        assign stage_in[0] = '{data: data_pre,
                               fill: (op_in == SRA) & in_data[WIDTH-1],
                               op: op_in,
                               shift: in_shift};
      end else begin : g_src_stg
        assign up_valid     = valid_q[gi-1];
        assign stage_in[gi] = stage_q[gi-1];
      end

      if (gi == NSTG - 1) begin : g_unrev
        assign res = ((stage_in[gi].op == SRL) || (stage_in[gi].op == SRA))
                   ? WIDTH'(bitrev(BITREV_MAX'(lvl_out[LAST]), WIDTH))
                   : lvl_out[LAST];
      end else begin : g_pass
        assign res = lvl_out[LAST];
      end

      // An empty stage always loads, so bubbles collapse under a stall.
      assign load[gi] = !vld_q || load[gi+1];

      always_comb begin
        stage_d      = stage_in[gi];
        stage_d.data = res;
        valid_d      = load[gi] ? up_valid : vld_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_q <= '0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= valid_d;
          if (load[gi] && up_valid) begin
            stg_q <= stage_d;
          end
        end
      end

      assign stage_q[gi] = stg_q;
      assign valid_q[gi] = vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: directed per-op and boundary vectors,
// back-pressure, streaming, mid-flight reset and a WIDTH/LVL_PER_REG sweep.
module tb_pipelined_shifter;

  localparam int NSTG_MAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sw_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_shift;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        sw_ready = 1'b1;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int sw_done   = 0;
  bit lat_check = 1'b0;

  typedef struct {
    logic [63:0] exp;
    int          cyc;
    string       name;
  } sb_t;

  sb_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  pipelined_shifter #(.WIDTH(64), .LVL_PER_REG(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Behavioural reference on a w-bit word held in the low bits of 64.
  function automatic logic [63:0] model(input logic [63:0] d, input int sh,
                                        input int op, input int w);
    logic [63:0] mask;
    logic [63:0] x;
    logic [63:0] r;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    x = d & mask;
    case (op)
      0: r = (x << sh) & mask;
      1: r = x >> sh;
      2: begin
        r = x >> sh;
        if (x[w-1]) r = r | (mask & ~(mask >> sh));
      end
      default: r = (sh == 0) ? x : (((x << sh) | (x >> (w - sh))) & mask);
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input string nm, input logic [63:0] d, input int sh,
                      input int op, input logic [63:0] exp);
    int g;
    in_valid = 1'b1;
    in_data  = d;
    in_shift = 6'(sh);
    in_op    = 2'(op);
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s handshake: in_ready stuck at 0, required 1", nm);
    end else begin
      sb.push_back('{exp: exp, cyc: cyc, name: nm});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Main-DUT monitor: pops on every output handshake, checks stall stability.
  logic [63:0] hold_d;
  logic        hold_v = 1'b0;
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("stall out_valid held", 64'(out_valid), 64'd1);
          chk("stall out_data stable", out_data, hold_d);
        end
        if (out_valid && out_ready) begin
          hold_v = 1'b0;
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected result: got %h, required no output", out_data);
          end else begin
            e = sb.pop_front();
            $display("[TB] %s -> %h (expected %h)", e.name, out_data, e.exp);
            chk({e.name, " data"}, out_data, e.exp);
            if (lat_check) chk({e.name, " latency"}, 64'(cyc - e.cyc), 64'(NSTG_MAIN));
          end
        end else if (out_valid) begin
          hold_v = 1'b1;
          hold_d = out_data;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  genvar gw;
  genvar gl;
  generate
    for (gw = 0; gw < 3; gw++) begin : g_sw_w
      for (gl = 0; gl < 3; gl++) begin : g_sw_l
        localparam int W  = (gw == 0) ? 8 : (gw == 1) ? 32 : 64;
        localparam int SH = $clog2(W);
        localparam int L  = (gl == 0) ? 1 : (gl == 1) ? 3 : SH;
        localparam int NS = (SH + L - 1) / L;

        logic          iv;
        logic          ir;
        logic          ov;
        logic [W-1:0]  id;
        logic [W-1:0]  od;
        logic [SH-1:0] is;
        logic [1:0]    io;
        logic [63:0]   eq[$];
        int            cq[$];

        pipelined_shifter #(.WIDTH(W), .LVL_PER_REG(L)) dut_sw (
          .clk       (clk),
          .rst_n     (sw_rst_n),
          .in_valid  (iv),
          .in_ready  (ir),
          .in_data   (id),
          .in_shift  (is),
          .in_op     (io),
          .out_valid (ov),
          .out_ready (sw_ready),
          .out_data  (od)
        );

        initial begin
          logic [63:0] r;
          int s;
          int o;
          iv = 1'b0;
          id = '0;
          is = '0;
          io = '0;
          wait (sw_rst_n === 1'b1);
          @(posedge clk);
          #1;
          for (int n = 0; n < 20; n++) begin
            r  = {$urandom, $urandom};
            s  = $urandom_range(0, W - 1);
            o  = $urandom_range(0, 3);
            iv = 1'b1;
            id = W'(r);
            is = SH'(s);
            io = 2'(o);
            @(negedge clk);
            n_tests++;
            if (!ir) begin
              n_fail++;
              $display("FAIL sweep W=%0d L=%0d in_ready: got 0, required 1", W, L);
            end else begin
              eq.push_back(model(r, s, o, W));
              cq.push_back(cyc);
            end
            @(posedge clk);
            #1;
          end
          iv = 1'b0;
          repeat (NS + 4) @(posedge clk);
          chk($sformatf("sweep W=%0d L=%0d leftover", W, L), 64'(eq.size()), 64'd0);
          sw_done++;
        end

        initial begin
          logic [63:0] e;
          int c;
          forever begin
            @(negedge clk);
            if (sw_rst_n && ov) begin
              if (eq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sweep W=%0d L=%0d unexpected: got %h", W, L, od);
              end else begin
                e = eq.pop_front();
                c = cq.pop_front();
                chk($sformatf("sweep W=%0d L=%0d data", W, L), 64'(od), 64'(e[W-1:0]));
                chk($sformatf("sweep W=%0d L=%0d latency", W, L), 64'(cyc - c), 64'(NS));
              end
            end
          end
        end
      end
    end
  endgenerate

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int s;
    int o;
    int g;
    rst_n     = 1'b0;
    sw_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", out_data, 64'd0);
    rst_n    = 1'b1;
    sw_rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    lat_check = 1'b1;
    send("SLL 4", 64'h8000_0000_0000_0001, 4, 0, 64'h0000_0000_0000_0010); drain();
    send("SRL 4", 64'h8000_0000_0000_0001, 4, 1, 64'h0800_0000_0000_0000); drain();
    send("SRA 4", 64'h8000_0000_0000_0001, 4, 2, 64'hF800_0000_0000_0000); drain();
    send("ROL 4", 64'h8000_0000_0000_0001, 4, 3, 64'h0000_0000_0000_0018); drain();

    for (int op = 0; op < 4; op++) begin
      send($sformatf("ones shift0 op%0d", op), 64'hFFFF_FFFF_FFFF_FFFF, 0, op,
           64'hFFFF_FFFF_FFFF_FFFF);
    end
    send("ones SLL 63", 64'hFFFF_FFFF_FFFF_FFFF, 63, 0, 64'h8000_0000_0000_0000);
    send("ones SRL 63", 64'hFFFF_FFFF_FFFF_FFFF, 63, 1, 64'h0000_0000_0000_0001);
    send("ones SRA 63", 64'hFFFF_FFFF_FFFF_FFFF, 63, 2, 64'hFFFF_FFFF_FFFF_FFFF);
    send("ones ROL 63", 64'hFFFF_FFFF_FFFF_FFFF, 63, 3, 64'hFFFF_FFFF_FFFF_FFFF);
    send("pos SRA 63", 64'h7FFF_0000_0000_0000, 63, 2, 64'h0000_0000_0000_0000);
    drain();

    lat_check = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          r = 64'h0123_4567_89AB_CDEF ^ (64'(i) << 40);
          s = (i * 7) % 64;
          send($sformatf("bp word %0d", i), r, s, i % 4, model(r, s, i % 4, 64));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall in_ready", 64'(in_ready), 64'd0);
        chk("stall depth", 64'(sb.size()), 64'd3);
        chk("stall out_valid", 64'(out_valid), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    lat_check = 1'b1;
    for (int i = 0; i < 100; i++) begin
      r = {$urandom, $urandom};
      s = $urandom_range(0, 63);
      o = $urandom_range(0, 3);
      send($sformatf("rand %0d", i), r, s, o, model(r, s, o, 64));
    end
    drain();

    lat_check = 1'b0;
    out_ready = 1'b0;
    send("flight A", 64'h1111_2222_3333_4444, 1, 0, 64'h2222_4444_6666_8888);
    send("flight B", 64'h5555_6666_7777_8888, 2, 3, 64'h5555_9999_DDDE_2221);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in-flight out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset out_data", out_data, 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("after reset in_ready", 64'(in_ready), 64'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("no result after reset", 64'(out_valid), 64'd0);

    g = 0;
    while (sw_done < 9 && g < 5000) begin
      @(posedge clk);
      g++;
    end
    chk("sweep completion", 64'(sw_done), 64'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined successor to the team's 64-bit combinational left barrel shifter. Adds four shift modes: logical left, logical right, arithmetic right and rotate left. Pipeline depth is configurable, and a valid/ready handshake gives full back-pressure. It sits in the MDCLCG datapath between the multiplier output and the state-update/output-scramble logic, and is reusable wherever a registered variable shift is needed.

## Interface
- `WIDTH`, 64: data width; power of two, ≥ 2.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived; do not override).
- `LVL_PER_REG`, 2: mux levels between pipeline registers; 1..SHW.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: block can accept the input this cycle.
- `in_data` input WIDTH: operand.
- `in_shift` input SHW: shift amount, unsigned, 0..WIDTH-1.
- `in_op` input 2: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output WIDTH: shifted result.

## Operation
- Log-shifter with SHW mux levels. Level k conditionally shifts by 2^k under `in_shift[k]`, LSB level first.
- SRL and SRA are implemented as bit-reverse → left shift → bit-reverse. One shift core serves all modes.
- Fill bit per level:
  - SLL/SRL: 0.
  - SRA: `in_data[WIDTH-1]`, captured at input and carried down the pipe.
  - ROL: wrapped bits from the same word, so no bits are lost.
- Op, fill bit and the remaining shift bits travel with the data through each register stage.
- Results:
  - Shift 0 → `out_data` = `in_data` for every op.
  - Shift WIDTH-1, SLL → `in_data[0]` in the MSB, zeros elsewhere.
  - Shift WIDTH-1, SRA → WIDTH copies of the sign bit.
- Pipeline: `NSTG = ceil(SHW / LVL_PER_REG)` register stages. Each stage has its own valid bit.
- Stage i loads when its valid is low or the stage after it is loading. The last stage's "next" is `out_ready`.
- `in_ready` = stage 0 can load. This is combinational from `out_ready` back through the stage valids, with no comb path from `in_valid`.
- Transfer happens only when valid and ready are both high on the same edge. Data is held stable while `out_valid & !out_ready`.
- Bubbles collapse: an empty stage accepts new data even while downstream is stalled.

## Timing
- Latency: `NSTG` cycles from input handshake to `out_valid`. With WIDTH=64 and LVL_PER_REG=2, latency is 3.
- Throughput: 1 word/cycle with `out_ready` held high.
- Reset (async assert, sync-safe deassert handled externally):
  - All stage valids are 0, so `out_valid` = 0.
  - `out_data` = 0 and all pipeline data registers are 0.
  - `in_ready` = 1 in the first cycle after reset deassert.
- Reset mid-operation: all in-flight words are discarded, with no partial output.
- Full pipeline with `out_ready` low: `in_ready` = 0 and no stage changes.
- Raising `out_ready` again lets all stages advance in the same cycle, with `in_ready` = 1.
- A simultaneous output pop and input push on a full pipe is allowed and loses no word.

## Structure
- Shared package `mdclcg_pkg`:
  - `shift_op_e` enum (`SLL`, `SRL`, `SRA`, `ROL`).
  - Default `WIDTH` constant.
  - `bitrev` function.
- One sub-module, `shift_level`: a parametrised single mux level (`WIDTH`, `AMT`) with data, fill, rotate-enable and select inputs. It is instantiated SHW times inside a generate loop. Registers are placed every `LVL_PER_REG` levels in the top module.

## Test plan
- Reset then idle:
  - Required: `out_valid` = 0, `out_data` = 0, `in_ready` = 1.
  - Assert `rst_n` low with 2 words in flight → `out_valid` drops immediately, and no result appears after release.
- Per-op single word, WIDTH=64:
  - `in_data` = 0x8000_0000_0000_0001, shift 4.
  - SLL → 0x0000_0000_0000_0010.
  - SRL → 0x0800_0000_0000_0000.
  - SRA → 0xF800_0000_0000_0000.
  - ROL → 0x0000_0000_0000_0018.
  - Each result arrives exactly 3 cycles after the handshake.
- Boundaries with `in_data` = 0xFFFF_FFFF_FFFF_FFFF:
  - Shift 0, all ops → input unchanged.
  - Shift 63: SLL → 0x8000_0000_0000_0000, SRL → 0x1, SRA → all ones, ROL → all ones.
- Back-pressure:
  - Stream 10 words with `out_ready` low on cycles 4–7.
  - Required: the pipe fills to 3 words, `in_ready` = 0, `out_data` is stable during the stall.
  - All 10 results appear in order with no loss or duplication.
- Throughput: 100 random words with `out_ready` = 1 → one result per cycle after a 3-cycle fill, each matching a golden model.
- Parameter sweep:
  - WIDTH = 8/32/64 with LVL_PER_REG = 1/3/SHW, random ops and shifts.
  - Required: latency equals `NSTG` and every result matches the golden model.
  - WIDTH=8, LVL_PER_REG=3 gives a 1-cycle latency.
